// File: rtl/vga_control_if.sv
// Piece-geometry bundle between game logic and the VGA playfield block:
// cell coordinates in, pixel-space bounds and validity flags back out.
interface vga_control_if;
  logic [3:0] block1_x, block2_x, block3_x, block4_x;
  logic [4:0] block1_y, block2_y, block3_y, block4_y;
  logic [9:0] newblock1_x1, newblock1_x2, newblock1_y1, newblock1_y2;
  logic [9:0] newblock2_x1, newblock2_x2, newblock2_y1, newblock2_y2;
  logic [9:0] newblock3_x1, newblock3_x2, newblock3_y1, newblock3_y2;
  logic [9:0] newblock4_x1, newblock4_x2, newblock4_y1, newblock4_y2;
  logic [3:0] block_valid;

  modport master (
    output block1_x, block2_x, block3_x, block4_x,
    output block1_y, block2_y, block3_y, block4_y,
    input  newblock1_x1, newblock1_x2, newblock1_y1, newblock1_y2,
    input  newblock2_x1, newblock2_x2, newblock2_y1, newblock2_y2,
    input  newblock3_x1, newblock3_x2, newblock3_y1, newblock3_y2,
    input  newblock4_x1, newblock4_x2, newblock4_y1, newblock4_y2,
    input  block_valid
  );

  modport slave (
    input  block1_x, block2_x, block3_x, block4_x,
    input  block1_y, block2_y, block3_y, block4_y,
    output newblock1_x1, newblock1_x2, newblock1_y1, newblock1_y2,
    output newblock2_x1, newblock2_x2, newblock2_y1, newblock2_y2,
    output newblock3_x1, newblock3_x2, newblock3_y1, newblock3_y2,
    output newblock4_x1, newblock4_x2, newblock4_y1, newblock4_y2,
    output block_valid
  );
endinterface

// File: rtl/vga_control.sv
// Tetris playfield geometry: pixel-clock divider, cell-to-pixel bound
// mapping and the per-pixel piece hit test feeding the raster colour mux.
module vga_control #(
  parameter int DIV   = 4,
  parameter int CELL  = 16,
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int X_OFF = 235,
  parameter int Y_OFF = 60
) (
  input  logic         in_clk,
  input  logic         rst_n,
  vga_control_if.slave pieces,
  input  logic         currentmap,
  input  logic [9:0]   h_pos,
  input  logic [9:0]   v_pos,
  output logic         pix_en,
  output logic         pix_clk,
  output logic [2:0]   hit,
  output logic         newmap
);

  localparam int CW = $clog2(DIV);
  localparam int SH = $clog2(CELL);

  logic [CW-1:0] r_cnt;

  // Outputs are decoded from the counter value of the previous cycle, so the
  // first strobe lands DIV clocks after reset release.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      pix_en  <= 1'b0;
      pix_clk <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + 1'b1;
      pix_en  <= (r_cnt == CW'(DIV - 1));
      pix_clk <= (r_cnt >= CW'(DIV / 2));
    end
  end

  logic [3:0]  w_x  [4];
  logic [4:0]  w_y  [4];
  logic [9:0]  w_x1 [4];
  logic [9:0]  w_x2 [4];
  logic [9:0]  w_y1 [4];
  logic [9:0]  w_y2 [4];
  logic [3:0]  w_valid;
  logic [2:0]  w_hit;
  logic [10:0] w_h;
  logic [10:0] w_v;

  assign w_x[0] = pieces.block1_x;
  assign w_x[1] = pieces.block2_x;
  assign w_x[2] = pieces.block3_x;
  assign w_x[3] = pieces.block4_x;
  assign w_y[0] = pieces.block1_y;
  assign w_y[1] = pieces.block2_y;
  assign w_y[2] = pieces.block3_y;
  assign w_y[3] = pieces.block4_y;
  assign w_h    = {1'b0, h_pos};
  assign w_v    = {1'b0, v_pos};

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_valid[n] = (32'(w_x[n]) < COLS) && (32'(w_y[n]) < ROWS);
      w_x1[n]    = '0;
      w_x2[n]    = '0;
      w_y1[n]    = '0;
      w_y2[n]    = '0;
      if (w_valid[n]) begin
        w_x1[n] = 10'(w_x[n]) << SH;
        w_x2[n] = (10'(w_x[n]) << SH) + 10'(CELL);
        w_y1[n] = 10'(w_y[n]) << SH;
        w_y2[n] = (10'(w_y[n]) << SH) + 10'(CELL);
      end
    end
  end

  // Scanning from cell 4 down to 1 lets the lowest index win on overlap.
  always_comb begin
    w_hit = '0;
    for (int n = 3; n >= 0; n--) begin
      if (w_valid[n] &&
          (11'(X_OFF) + {1'b0, w_x1[n]} < w_h) && (w_h < 11'(X_OFF) + {1'b0, w_x2[n]}) &&
          (11'(Y_OFF) + {1'b0, w_y1[n]} < w_v) && (w_v < 11'(Y_OFF) + {1'b0, w_y2[n]}))
        w_hit = 3'(n + 1);
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      pieces.newblock1_x1 <= '0;
      pieces.newblock1_x2 <= '0;
      pieces.newblock1_y1 <= '0;
      pieces.newblock1_y2 <= '0;
      pieces.newblock2_x1 <= '0;
      pieces.newblock2_x2 <= '0;
      pieces.newblock2_y1 <= '0;
      pieces.newblock2_y2 <= '0;
      pieces.newblock3_x1 <= '0;
      pieces.newblock3_x2 <= '0;
      pieces.newblock3_y1 <= '0;
      pieces.newblock3_y2 <= '0;
      pieces.newblock4_x1 <= '0;
      pieces.newblock4_x2 <= '0;
      pieces.newblock4_y1 <= '0;
      pieces.newblock4_y2 <= '0;
      pieces.block_valid  <= '0;
      hit                 <= '0;
      newmap              <= 1'b0;
    end else begin
      pieces.newblock1_x1 <= w_x1[0];
      pieces.newblock1_x2 <= w_x2[0];
      pieces.newblock1_y1 <= w_y1[0];
      pieces.newblock1_y2 <= w_y2[0];
      pieces.newblock2_x1 <= w_x1[1];
      pieces.newblock2_x2 <= w_x2[1];
      pieces.newblock2_y1 <= w_y1[1];
      pieces.newblock2_y2 <= w_y2[1];
      pieces.newblock3_x1 <= w_x1[2];
      pieces.newblock3_x2 <= w_x2[2];
      pieces.newblock3_y1 <= w_y1[2];
      pieces.newblock3_y2 <= w_y2[2];
      pieces.newblock4_x1 <= w_x1[3];
      pieces.newblock4_x2 <= w_x2[3];
      pieces.newblock4_y1 <= w_y1[3];
      pieces.newblock4_y2 <= w_y2[3];
      pieces.block_valid  <= w_valid;
      hit                 <= w_hit;
      newmap              <= currentmap;
    end
  end

endmodule

// File: tb/tb_vga_control.sv
// Self-checking bench for vga_control: reset/divider timing, a table of
// geometry and hit-boundary vectors, async reset mid-frame and random sweeps.
module tb_vga_control;

  logic       in_clk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       currentmap = 1'b0;
  logic [9:0] h_pos      = '0;
  logic [9:0] v_pos      = '0;
  logic       pix_en;
  logic       pix_clk;
  logic [2:0] hit;
  logic       newmap;

  vga_control_if bus ();

  vga_control #(
    .DIV(4), .CELL(16), .COLS(10), .ROWS(20), .X_OFF(235), .Y_OFF(60)
  ) dut (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .pieces    (bus),
    .currentmap(currentmap),
    .h_pos     (h_pos),
    .v_pos     (v_pos),
    .pix_en    (pix_en),
    .pix_clk   (pix_clk),
    .hit       (hit),
    .newmap    (newmap)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    int x [4];
    int y [4];
    int h;
    int v;
    int expHit;
    int expValid;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   tbX [4];
  int   tbY [4];
  int   tbH;
  int   tbV;
  bit   tbMap;

  function automatic vec_t mk(int x0, int y0, int x1, int y1, int x2, int y2,
                              int x3, int y3, int h, int v, int eh, int ev);
    vec_t r;
    r.x[0] = x0; r.y[0] = y0;
    r.x[1] = x1; r.y[1] = y1;
    r.x[2] = x2; r.y[2] = y2;
    r.x[3] = x3; r.y[3] = y3;
    r.h = h; r.v = v; r.expHit = eh; r.expValid = ev;
    return r;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.block1_x = 4'(tbX[0]);
    bus.block2_x = 4'(tbX[1]);
    bus.block3_x = 4'(tbX[2]);
    bus.block4_x = 4'(tbX[3]);
    bus.block1_y = 5'(tbY[0]);
    bus.block2_y = 5'(tbY[1]);
    bus.block3_y = 5'(tbY[2]);
    bus.block4_y = 5'(tbY[3]);
    h_pos        = 10'(tbH);
    v_pos        = 10'(tbV);
    currentmap   = tbMap;
  endtask

  function automatic int dutBound(int n, int k);
    case (n * 4 + k)
      0:  return int'(bus.newblock1_x1);
      1:  return int'(bus.newblock1_x2);
      2:  return int'(bus.newblock1_y1);
      3:  return int'(bus.newblock1_y2);
      4:  return int'(bus.newblock2_x1);
      5:  return int'(bus.newblock2_x2);
      6:  return int'(bus.newblock2_y1);
      7:  return int'(bus.newblock2_y2);
      8:  return int'(bus.newblock3_x1);
      9:  return int'(bus.newblock3_x2);
      10: return int'(bus.newblock3_y1);
      11: return int'(bus.newblock3_y2);
      12: return int'(bus.newblock4_x1);
      13: return int'(bus.newblock4_x2);
      14: return int'(bus.newblock4_y1);
      default: return int'(bus.newblock4_y2);
    endcase
  endfunction

  function automatic bit cellValid(int n);
    return (tbX[n] < 10) && (tbY[n] < 20);
  endfunction

  // Reference: first cell in index order whose 15x15 interior holds the pixel.
  function automatic int modelHit();
    for (int n = 0; n < 4; n++) begin
      int l = 235 + tbX[n] * 16;
      int t = 60 + tbY[n] * 16;
      if (cellValid(n) && (l < tbH) && (tbH < l + 16) && (t < tbV) && (tbV < t + 16))
        return n + 1;
    end
    return 0;
  endfunction

  task automatic checkAll(string tag, int expHit);
    int expValid = 0;
    for (int n = 0; n < 4; n++) begin
      int e [4];
      e[0] = cellValid(n) ? tbX[n] * 16 : 0;
      e[1] = cellValid(n) ? tbX[n] * 16 + 16 : 0;
      e[2] = cellValid(n) ? tbY[n] * 16 : 0;
      e[3] = cellValid(n) ? tbY[n] * 16 + 16 : 0;
      if (cellValid(n)) expValid += (1 << n);
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("%s bound%0d_%0d", tag, n + 1, k), dutBound(n, k), e[k]);
    end
    checkOutput({tag, " block_valid"}, int'(bus.block_valid), expValid);
    checkOutput({tag, " hit"}, int'(hit), expHit);
    checkOutput({tag, " newmap"}, int'(newmap), int'(tbMap));
  endtask

  task automatic checkDivider(string tag, int cycles);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge in_clk);
      checkOutput($sformatf("%s pix_en@%0d", tag, k), int'(pix_en), (k % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("%s pix_clk@%0d", tag, k), int'(pix_clk), (((k - 1) % 4) >= 2) ? 1 : 0);
    end
  endtask

  task automatic loadVec(vec_t vv, bit m);
    for (int n = 0; n < 4; n++) begin
      tbX[n] = vv.x[n];
      tbY[n] = vv.y[n];
    end
    tbH   = vv.h;
    tbV   = vv.v;
    tbMap = m;
    applyStimulus();
  endtask

  initial begin
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10,   0,   0, 0, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 236,  61, 1, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 235,  61, 0, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 251,  61, 0, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 250,  75, 1, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 240,  60, 0, 15));
    vecs.push_back(mk(2,2, 9,19, 2,2,  5,10, 270,  95, 1, 15));
    vecs.push_back(mk(7,7, 9,19, 2,2,  5,10, 270,  95, 3, 15));
    vecs.push_back(mk(7,7, 10,0, 3,20, 5,10, 400,  65, 0, 9));
    vecs.push_back(mk(7,7, 10,0, 3,20, 5,10, 290, 385, 0, 9));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 320, 225, 4, 15));
    vecs.push_back(mk(0,0, 9,19, 3,5,  5,10, 394, 379, 2, 15));
    vecs.push_back(mk(15,31, 15,31, 15,31, 15,31, 400, 400, 0, 0));

    loadVec(vecs[0], 1'b1);
    repeat (10) @(negedge in_clk);
    checkOutput("reset pix_en", int'(pix_en), 0);
    checkOutput("reset pix_clk", int'(pix_clk), 0);
    checkOutput("reset hit", int'(hit), 0);
    checkOutput("reset newmap", int'(newmap), 0);
    checkOutput("reset block_valid", int'(bus.block_valid), 0);
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("reset bound%0d_%0d", n + 1, k), dutBound(n, k), 0);
    rst_n = 1'b1;
    checkDivider("startup", 16);

    checkOutput("map b2 x1", int'(bus.newblock2_x1), 144);
    checkOutput("map b2 x2", int'(bus.newblock2_x2), 160);
    checkOutput("map b2 y1", int'(bus.newblock2_y1), 304);
    checkOutput("map b2 y2", int'(bus.newblock2_y2), 320);
    checkOutput("map b3 x1", int'(bus.newblock3_x1), 48);
    checkOutput("map b3 y2", int'(bus.newblock3_y2), 96);
    checkOutput("map b4 y1", int'(bus.newblock4_y1), 160);
    checkOutput("map b4 x2", int'(bus.newblock4_x2), 96);

    for (int i = 0; i < vecs.size(); i++) begin
      loadVec(vecs[i], bit'(i % 2));
      @(negedge in_clk);
      checkOutput($sformatf("vec%0d valid", i), int'(bus.block_valid), vecs[i].expValid);
      checkAll($sformatf("vec%0d", i), vecs[i].expHit);
    end

    loadVec(vecs[11], 1'b1);
    @(negedge in_clk);
    checkOutput("pre-reset hit", int'(hit), 2);
    checkOutput("pre-reset newmap", int'(newmap), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async hit", int'(hit), 0);
    checkOutput("async newmap", int'(newmap), 0);
    checkOutput("async block_valid", int'(bus.block_valid), 0);
    checkOutput("async b2 x1", int'(bus.newblock2_x1), 0);
    @(negedge in_clk);
    rst_n = 1'b1;
    checkDivider("restart", 8);
    checkAll("post-reset", 2);

    repeat (300) begin
      int t;
      for (int n = 0; n < 4; n++) begin
        tbX[n] = int'($urandom_range(0, 11));
        tbY[n] = int'($urandom_range(0, 21));
      end
      t = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        tbH = int'($urandom_range(0, 639));
        tbV = int'($urandom_range(0, 479));
      end else begin
        tbH = 235 + tbX[t] * 16 + int'($urandom_range(0, 17)) - 1;
        tbV = 60 + tbY[t] * 16 + int'($urandom_range(0, 17)) - 1;
      end
      tbMap = bit'($urandom_range(0, 1));
      applyStimulus();
      @(negedge in_clk);
      checkAll("random", modelHit());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
